// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl
//   Resolves EX-stage branches and jumps into a registered PC redirect, and
//   squashes the wrong-path instructions. The pipeline predicts not-taken, so
//   only taken branch-class ops cause a redirect. The block also keeps
//   saturating counters of resolved branches and of taken branches.
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   ex_valid          EX holds a real (non-bubble) instruction
//   ex_br_op[3:0]     branch op; bit 3 marks the branch class
//   ex_br_taken       branch_logic decision for the EX instruction
//   ex_target[31:0]   branch/jump target address
//   stall             global stall; nothing advances while high
//   perf_clr          synchronous clear of both counters
//   pc_sel            next PC comes from pc_target
//   pc_target[31:0]   latched redirect address
//   flush_if_id/id_ex/ex_mem  squash the pipeline register on its next load
//   branch_cnt, taken_cnt     saturating performance counters
module branch_redirect_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic [3:0]       ex_br_op,
    input  logic             ex_br_taken,
    input  logic [31:0]      ex_target,
    input  logic             stall,
    input  logic             perf_clr,
    output logic             pc_sel,
    output logic [31:0]      pc_target,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic {IDLE = 1'b0, REDIRECT = 1'b1} state_t;

    state_t state, state_nxt;
    logic   resolve;
    logic   resolve_taken;

    // Only the class bit matters here; the condition itself was already
    // evaluated by branch_logic.
    logic   unused_op;
    assign unused_op = ^ex_br_op[2:0];

    // While redirecting, the EX instruction is on the wrong path, so
    // resolution is only possible from IDLE.
    assign resolve       = (state == IDLE) && ex_valid && ex_br_op[3] && !stall;
    assign resolve_taken = resolve && ex_br_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (resolve_taken) state_nxt = REDIRECT;
            // Hold the redirect across a stall so the PC load is not lost.
            REDIRECT: if (!stall)        state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pc_sel       = (state == REDIRECT);
        flush_if_id  = (state == REDIRECT);
        flush_id_ex  = (state == REDIRECT);
        flush_ex_mem = (state == REDIRECT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             pc_target <= 32'h0;
        else if (resolve_taken) pc_target <= ex_target;
    end

    // Clear has priority over a same-edge increment; counters stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt <= '0;
            taken_cnt  <= '0;
        end else if (perf_clr) begin
            branch_cnt <= '0;
            taken_cnt  <= '0;
        end else begin
            if (resolve && !(&branch_cnt))      branch_cnt <= branch_cnt + 1'b1;
            if (resolve_taken && !(&taken_cnt)) taken_cnt  <= taken_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
module tb_branch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ex_valid = 1'b0;
    logic [3:0]  ex_br_op = 4'h0;
    logic        ex_br_taken = 1'b0;
    logic [31:0] ex_target = 32'h0;
    logic        stall = 1'b0;
    logic        perf_clr = 1'b0;

    logic        pc_sel, f_ifid, f_idex, f_exmem;
    logic [31:0] pc_target, branch_cnt, taken_cnt;
    logic        pc_sel4, f4_ifid, f4_idex, f4_exmem;
    logic [31:0] pc_target4;
    logic [3:0]  branch_cnt4, taken_cnt4;

    always #5 clk = ~clk;

    branch_redirect_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_br_op(ex_br_op),
        .ex_br_taken(ex_br_taken), .ex_target(ex_target), .stall(stall),
        .perf_clr(perf_clr), .pc_sel(pc_sel), .pc_target(pc_target),
        .flush_if_id(f_ifid), .flush_id_ex(f_idex), .flush_ex_mem(f_exmem),
        .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
    );

    branch_redirect_ctrl #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_br_op(ex_br_op),
        .ex_br_taken(ex_br_taken), .ex_target(ex_target), .stall(stall),
        .perf_clr(perf_clr), .pc_sel(pc_sel4), .pc_target(pc_target4),
        .flush_if_id(f4_ifid), .flush_id_ex(f4_idex), .flush_ex_mem(f4_exmem),
        .branch_cnt(branch_cnt4), .taken_cnt(taken_cnt4)
    );

    typedef struct packed {
        logic        sel;
        logic [31:0] tgt;
        logic [31:0] br;
        logic [31:0] tk;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    event sample_now;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the DUT outputs against the oldest expectation.
    initial begin
        exp_t e;
        logic [3:0] b4, t4;
        forever begin
            @(negedge clk or sample_now);
            if (q.size() != 0) begin
                e  = q.pop_front();
                b4 = (e.br > 32'd15) ? 4'hF : e.br[3:0];
                t4 = (e.tk > 32'd15) ? 4'hF : e.tk[3:0];
                chk("pc_sel",     {31'h0, pc_sel}, {31'h0, e.sel});
                chk("flushes",    {29'h0, f_ifid, f_idex, f_exmem}, {29'h0, {3{e.sel}}});
                chk("pc_target",  pc_target, e.tgt);
                chk("branch_cnt", branch_cnt, e.br);
                chk("taken_cnt",  taken_cnt, e.tk);
                chk("w4_pc_sel",  {28'h0, pc_sel4, f4_ifid, f4_idex, f4_exmem}, {28'h0, {4{e.sel}}});
                chk("w4_target",  pc_target4, e.tgt);
                chk("w4_cnts",    {24'h0, branch_cnt4, taken_cnt4}, {24'h0, b4, t4});
            end
        end
    end

    task automatic push(input logic s, input logic [31:0] t, input logic [31:0] b, input logic [31:0] k);
        exp_t e;
        e.sel = s; e.tgt = t; e.br = b; e.tk = k;
        q.push_back(e);
    endtask

    // Apply one vector across one rising edge, then queue the expected outputs.
    task automatic vec(input logic v, input logic [3:0] op, input logic tk,
                       input logic [31:0] tgt, input logic st, input logic clr,
                       input logic e_sel, input logic [31:0] e_tgt,
                       input logic [31:0] e_br, input logic [31:0] e_tk);
        ex_valid = v; ex_br_op = op; ex_br_taken = tk; ex_target = tgt;
        stall = st; perf_clr = clr;
        @(posedge clk); #1;
        push(e_sel, e_tgt, e_br, e_tk);
        @(negedge clk);
    endtask

    task automatic rand_in();
        ex_valid = 1'($urandom); ex_br_op = 4'($urandom); ex_br_taken = 1'($urandom);
        ex_target = $urandom; stall = 1'($urandom); perf_clr = 1'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) begin
            rand_in();
            @(posedge clk); #1;
            push(1'b0, 32'h0, 32'h0, 32'h0);
            @(negedge clk);
        end
        rst_n = 1'b1;

        //   v  op       tk  target        st clr   sel tgt           br  tk
        vec(0, 4'b0000, 0, 32'h0,         0, 0,    0, 32'h0,         0,  0);
        vec(1, 4'b1000, 1, 32'h0000_0040, 0, 0,    1, 32'h40,        1,  1); // BEQ taken
        vec(0, 4'b0000, 0, 32'h0,         0, 0,    0, 32'h40,        1,  1);
        vec(1, 4'b1001, 0, 32'h80,        0, 0,    0, 32'h40,        2,  1); // BNE not taken
        vec(1, 4'b0000, 1, 32'h200,       0, 0,    0, 32'h40,        2,  1); // non-branch
        vec(0, 4'b1000, 1, 32'h240,       0, 0,    0, 32'h40,        2,  1); // bubble
        vec(1, 4'b1010, 1, 32'h100,       1, 0,    0, 32'h40,        2,  1); // JAL stalled
        vec(1, 4'b1010, 1, 32'h100,       1, 0,    0, 32'h40,        2,  1);
        vec(1, 4'b1010, 1, 32'h100,       0, 0,    1, 32'h100,       3,  2); // JAL resolves
        vec(1, 4'b1000, 1, 32'h300,       1, 0,    1, 32'h100,       3,  2); // held by stall
        vec(1, 4'b1000, 1, 32'h300,       1, 0,    1, 32'h100,       3,  2);
        vec(1, 4'b1000, 1, 32'h300,       1, 0,    1, 32'h100,       3,  2);
        vec(1, 4'b1000, 1, 32'h300,       0, 0,    0, 32'h100,       3,  2); // exit, EX ignored
        vec(1, 4'b1100, 1, 32'h500,       0, 0,    1, 32'h500,       4,  3); // BLT taken
        vec(1, 4'b1101, 1, 32'h600,       0, 0,    0, 32'h500,       4,  3); // ignored in REDIRECT
        vec(1, 4'b1111, 1, 32'h700,       0, 0,    1, 32'h700,       5,  4); // back-to-back BGEU
        vec(1, 4'b1110, 0, 32'h780,       1, 0,    1, 32'h700,       5,  4);
        vec(0, 4'b0000, 0, 32'h0,         0, 0,    0, 32'h700,       5,  4);
        vec(1, 4'b1000, 1, 32'h40,        0, 1,    1, 32'h40,        0,  0); // clear beats incr
        vec(0, 4'b0000, 0, 32'h0,         0, 0,    0, 32'h40,        0,  0);

        // Saturation: the 4-bit instance sticks at 4'hF, the 32-bit one keeps counting.
        for (int i = 1; i <= 17; i++) begin
            vec(1, 4'b1000, 1, 32'h1000 + i, 0, 0, 1, 32'h1000 + i, i, i);
            vec(0, 4'b0000, 0, 32'h0,        0, 0, 0, 32'h1000 + i, i, i);
        end
        vec(1, 4'b1001, 0, 32'h0,         0, 0,    0, 32'h1011,      18, 17);
        vec(1, 4'b1001, 0, 32'h0,         0, 1,    0, 32'h1011,      0,  0); // clear while saturated

        // Reset in the middle of a redirect aborts it immediately.
        vec(1, 4'b1000, 1, 32'h900,       0, 0,    1, 32'h900,       1,  1);
        stall = 1'b1;
        #2 rst_n = 1'b0;
        #1 push(1'b0, 32'h0, 32'h0, 32'h0);
        -> sample_now;
        rand_in();
        @(posedge clk); #1;
        push(1'b0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        vec(0, 4'b0000, 0, 32'h0,         0, 0,    0, 32'h0,         0,  0);
        vec(1, 4'b1001, 1, 32'h44,        0, 0,    1, 32'h44,        1,  1);
        vec(0, 4'b0000, 0, 32'h0,         0, 0,    0, 32'h44,        1,  1);

        repeat (5) if (q.size() != 0) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Sequencer for branch/jump resolution in the RV32IM pipeline. It samples the EX-stage branch decision (the 1-bit `out` of `branch_logic` plus the 4-bit branch op), and turns a taken branch or jump into a registered PC redirect. It also generates the squash pulses for the wrong-path instructions in IF/ID, ID/EX and EX/MEM, and keeps saturating branch/taken performance counters. The pipeline predicts not-taken; this block is the sole source of `pc_sel` and the branch flushes.

## Interface
- `CNT_W`, 32: width of the performance counters.
- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ex_valid`  in  1  the EX stage holds a real, non-bubble instruction.
- `ex_br_op`  in  4  branch op from ID/EX. `op[3]=1` means branch class: 1000 BEQ, 1001 BNE, 1100 BLT, 1101 BGE, 1110 BLTU, 1111 BGEU, 1010 JAL/JALR.
- `ex_br_taken`  in  1  `out` of `branch_logic` for the current EX instruction.
- `ex_target`  in  32  computed branch/jump target address.
- `stall`  in  1  global pipeline stall (memory or mul/div busy); no pipeline register advances while it is high.
- `perf_clr`  in  1  synchronous clear of both counters.
- `pc_sel`  out  1  1 selects `pc_target` as the next PC.
- `pc_target`  out  32  latched redirect address.
- `flush_if_id`, `flush_id_ex`, `flush_ex_mem`  out  1 each  squash the corresponding pipeline register on its next load.
- `branch_cnt`  out  CNT_W  resolved branch-class instructions.
- `taken_cnt`  out  CNT_W  resolved taken branch-class instructions.

## Operation
- State machine has two states: IDLE and REDIRECT. Reset enters IDLE.
- Resolve event: state IDLE, `ex_valid=1`, `ex_br_op[3]=1` and `stall=0`, sampled at a rising edge.
  - No resolve is sampled while `stall=1`. The EX instruction is held, so it resolves on the first unstalled edge.
- On a resolve with `ex_br_taken=1`:
  - `pc_target` <= `ex_target`.
  - State moves to REDIRECT.
- On a resolve with `ex_br_taken=0`, state stays IDLE and no flush is issued.
- Ops with `op[3]=0` are ignored entirely: no count and no redirect. `op=1010` is always treated as taken by `branch_logic`; this block does not re-decode it.
- REDIRECT state:
  - `pc_sel=1` and all three flush outputs are 1.
  - Inputs `ex_*` are ignored, because the EX instruction at that point is on the wrong path.
  - On an edge with `stall=0`, state returns to IDLE.
  - On an edge with `stall=1`, state stays in REDIRECT with all outputs held, so the redirect is not lost.
- Outputs in IDLE: `pc_sel=0`, all flushes 0. `pc_target` holds its last value.
- Counters:
  - On each resolve event, `branch_cnt` increments.
  - `taken_cnt` also increments if the branch is taken.
  - Both saturate at all-ones; they do not wrap.
- `perf_clr=1` at an edge sets both counters to 0. Clear wins over a simultaneous increment. `perf_clr` has no effect on the FSM.

## Timing
- Reset values: state IDLE, `pc_sel=0`, all flushes 0, `pc_target=32'h0`, both counters 0. Reset is applied asynchronously on the `rst_n` falling edge, and the block leaves reset on the first rising `clk` edge after `rst_n=1`.
- Redirect latency: a taken branch resolved at edge k gives `pc_sel` and the flushes high during cycle k..k+1. The PC loads `pc_target` at edge k+1 if `stall=0`.
- Redirect width: the pulse lasts exactly 1 cycle with no stall, or 1 + N cycles when `stall` is high on N consecutive edges while in REDIRECT.
- Back-to-back branches: the first edge after REDIRECT exits is an IDLE cycle, so the earliest next resolve is at edge k+2. This is legal because the pipeline refills from the flushed state.
- A not-taken branch has zero-cycle penalty, and counters update at the resolve edge.
- If `rst_n` is asserted in REDIRECT, the redirect is aborted immediately: outputs go to their reset values and no pending state survives.

## Test plan
- Reset with `rst_n=0`, random inputs -> `pc_sel=0`, all flushes 0, `pc_target=0`, both counters 0, even mid-REDIRECT.
- BEQ, `op=1000`, `ex_br_taken=1`, `ex_target=32'h0000_0040`, `stall=0` -> one cycle with `pc_sel=1`, `pc_target=32'h40`, all three flushes 1; then IDLE; `branch_cnt=1`, `taken_cnt=1`.
- BNE, `op=1001`, `ex_br_taken=0` -> no `pc_sel`, no flush; `branch_cnt` +1, `taken_cnt` unchanged. With `op=0000` and `ex_valid=1` -> nothing changes.
- JAL, `op=1010`, taken, target `32'h100`, with `stall=1` first (no resolve for 2 cycles), then 0 for the resolve, then `stall=1` for 3 edges in REDIRECT -> `pc_sel` and flushes high for 4 cycles, `pc_target=32'h100`, counters +1 once.
- Taken branch resolved, then a different valid branch op presented in EX during REDIRECT -> ignored: no second redirect and no extra count.
- `CNT_W=4`:
  - 16 taken resolves -> both counters saturate at 4'hF.
  - `perf_clr=1` on the same edge as a resolve -> both counters 0.
